// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: segment width, hex glyph table (active-high), blank glyph
// and the output polarity helper used by the scan controller.
package seg_pkg;

    localparam int SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    // Segment order {g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
    localparam logic [SEG_W-1:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [SEG_W-1:0] seg_apply_pol(input logic [SEG_W-1:0] seg,
                                                       input logic active_low);
        return active_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Nibble to active-high segment pattern, forced blank when requested.
// Purely combinational; no backpressure.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0]       nibble,
    input  logic             blank,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_HEX[nibble];
        if (blank) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed N-digit 7-segment scanner with prescaler, frame-aligned valid/ready load,
// leading-zero blanking and per-digit blink. Outputs update one cycle after each scan tick.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int PRESCALE     = 50000,
    parameter int BLINK_FRAMES = 32,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [4*N_DIGITS-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  blank_lz_i,
    input  logic [N_DIGITS-1:0]   blink_mask_i,
    output logic [SEG_W-1:0]      seg_o,
    output logic [N_DIGITS-1:0]   an_o,
    output logic                  frame_o
);

    localparam int DATA_W  = 4 * N_DIGITS;
    localparam int PRESC_W = $clog2(PRESCALE);
    localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic POL_LOW = (ACTIVE_LOW != 0);
    localparam logic [N_DIGITS-1:0] AN_OFF = POL_LOW ? '1 : '0;

    logic [PRESC_W-1:0] presc_cnt;
    logic [IDX_W-1:0]   idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_hidden;
    logic [DATA_W-1:0]  shown;
    logic [DATA_W-1:0]  pending;
    logic               pend_v;

    logic               tick;
    logic               wrap;
    logic               blink_wrap;
    logic [N_DIGITS-1:0] upper_zero;
    logic [3:0]         cur_nib;
    logic               cur_blank;
    logic [N_DIGITS-1:0] an_sel;
    logic [SEG_W-1:0]   seg_hi;

    assign tick       = (presc_cnt == PRESC_W'(PRESCALE - 1));
    assign wrap       = tick && (idx == IDX_W'(N_DIGITS - 1));
    assign blink_wrap = (blink_cnt == BLINK_W'(BLINK_FRAMES - 1));
    assign frame_o    = wrap;
    assign ready_o    = !pend_v;

    // upper_zero[k]: every nibble from k up to the top of the shown word is zero.
    for (genvar k = 0; k < N_DIGITS; k++) begin : g_lz
        assign upper_zero[k] = ~|shown[DATA_W-1:4*k];
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_blank = 1'b0;
        an_sel    = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib   = shown[4*k +: 4];
                cur_blank = (blank_lz_i && (k != 0) && upper_zero[k]) ||
                            (blink_hidden && blink_mask_i[k]);
                an_sel[k] = 1'b1;
            end
        end
    end

    seg_hex_decode u_dec (
        .nibble (cur_nib),
        .blank  (cur_blank),
        .seg    (seg_hi)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_cnt    <= '0;
            idx          <= '0;
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
            shown        <= '0;
            pending      <= '0;
            pend_v       <= 1'b0;
            seg_o        <= seg_apply_pol(SEG_BLANK, POL_LOW);
            an_o         <= AN_OFF;
        end else begin
            presc_cnt <= tick ? '0 : presc_cnt + 1'b1;

            if (valid_i && !pend_v) begin
                pending <= data_i;
                pend_v  <= 1'b1;
            end

            if (tick) begin
                idx   <= wrap ? '0 : idx + 1'b1;
                seg_o <= seg_apply_pol(seg_hi, POL_LOW);
                an_o  <= POL_LOW ? ~an_sel : an_sel;
            end

            // Commit only between frames so a frame never mixes old and new digits.
            if (wrap) begin
                if (pend_v) begin
                    shown  <= pending;
                    pend_v <= 1'b0;
                end
                if (blink_wrap) begin
                    blink_cnt    <= '0;
                    blink_hidden <= ~blink_hidden;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: 4 digits, prescale 4, blink every 2 frames, active-low.
module tb_seg_scan_ctrl;

    logic        clk          = 1'b0;
    logic        rst_i        = 1'b1;
    logic [15:0] data_i       = '0;
    logic        valid_i      = 1'b0;
    logic        blank_lz_i   = 1'b0;
    logic [3:0]  blink_mask_i = '0;
    logic        ready_o;
    logic        frame_o;
    logic [6:0]  seg_o;
    logic [3:0]  an_o;

    int errors = 0;
    int checks = 0;

    logic [6:0] fs [4];
    logic [3:0] fa [4];

    seg_scan_ctrl #(
        .N_DIGITS     (4),
        .PRESCALE     (4),
        .BLINK_FRAMES (2),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .blank_lz_i   (blank_lz_i),
        .blink_mask_i (blink_mask_i),
        .seg_o        (seg_o),
        .an_o         (an_o),
        .frame_o      (frame_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns at the falling edge inside the cycle where frame_o is high.
    task automatic wait_frame(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_o) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        assert (seen) else begin
            errors++;
            $error("FAIL %s: observed=no frame_o expected=frame_o within 100 cycles", tag);
        end
    endtask

    // Digit 0 is latched `first` edges from now, the rest at 4-edge spacing.
    task automatic read_frame(input int first);
        repeat (first) @(posedge clk);
        #1;
        fs[0] = seg_o;
        fa[0] = an_o;
        for (int k = 1; k < 4; k++) begin
            repeat (4) @(posedge clk);
            #1;
            fs[k] = seg_o;
            fa[k] = an_o;
        end
    endtask

    task automatic chk_frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] e [4];
        logic [3:0] ea;
        e[0] = e0;
        e[1] = e1;
        e[2] = e2;
        e[3] = e3;
        for (int k = 0; k < 4; k++) begin
            ea = ~(4'b0001 << k);
            chk($sformatf("%s_seg_d%0d", tag, k), fs[k], e[k]);
            chk($sformatf("%s_an_d%0d", tag, k), fa[k], ea);
        end
    endtask

    initial begin
        // Reset state, then first tick 4 cycles after release selects digit 0.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg", seg_o, 7'h7F);
        chk("rst_an", an_o, 4'hF);
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_frame", frame_o, 1'b0);
        rst_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_tick_an", an_o, 4'hF);
        @(posedge clk);
        #1;
        chk("first_an", an_o, 4'hE);
        chk("first_seg", seg_o, 7'h40);

        // Mid-frame load of 0x1234, visible only from the next frame.
        wait_frame("t2_sync");
        repeat (6) @(negedge clk);
        data_i  = 16'h1234;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        chk("t2_ready_low", ready_o, 1'b0);
        chk("t2_unchanged", seg_o, 7'h40);
        wait_frame("t2_frame");
        chk("t2_ready_at_frame", ready_o, 1'b0);
        @(posedge clk);
        #1;
        chk("t2_ready_back", ready_o, 1'b1);
        read_frame(4);
        chk_frame("t2", 7'h19, 7'h30, 7'h24, 7'h79);

        // Back-to-back: second word waits for the commit of the first.
        @(negedge clk);
        data_i  = 16'h0001;
        valid_i = 1'b1;
        @(negedge clk);
        chk("t3_ready_low", ready_o, 1'b0);
        data_i = 16'h0002;
        wait_frame("t3_frame");
        chk("t3_ready_at_frame", ready_o, 1'b0);
        @(posedge clk);
        #1;
        chk("t3_ready_after_commit", ready_o, 1'b1);
        @(posedge clk);
        #1;
        chk("t3_second_accepted", ready_o, 1'b0);
        valid_i = 1'b0;
        read_frame(3);
        chk_frame("t3_first", 7'h79, 7'h40, 7'h40, 7'h40);
        read_frame(4);
        chk_frame("t3_second", 7'h24, 7'h40, 7'h40, 7'h40);

        // Leading-zero blanking.
        blank_lz_i = 1'b1;
        @(negedge clk);
        data_i  = 16'h0010;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        wait_frame("t4a_frame");
        @(posedge clk);
        #1;
        read_frame(4);
        chk_frame("t4a", 7'h40, 7'h79, 7'h7F, 7'h7F);
        @(negedge clk);
        data_i  = 16'h0000;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        wait_frame("t4b_frame");
        @(posedge clk);
        #1;
        read_frame(4);
        chk_frame("t4b", 7'h40, 7'h7F, 7'h7F, 7'h7F);
        blank_lz_i = 1'b0;

        // Blink from a fresh reset: visible, hidden, hidden, visible.
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i        = 1'b0;
        blink_mask_i = 4'b0001;
        data_i       = 16'h8888;
        valid_i      = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        wait_frame("t5_frame");
        @(posedge clk);
        #1;
        read_frame(4);
        chk_frame("t5_f1", 7'h00, 7'h00, 7'h00, 7'h00);
        read_frame(4);
        chk_frame("t5_f2", 7'h7F, 7'h00, 7'h00, 7'h00);
        read_frame(4);
        chk_frame("t5_f3", 7'h7F, 7'h00, 7'h00, 7'h00);
        read_frame(4);
        chk_frame("t5_f4", 7'h00, 7'h00, 7'h00, 7'h00);
        blink_mask_i = 4'b0000;

        // Reset with a load pending: discarded, display blanks, scan restarts.
        @(negedge clk);
        data_i  = 16'hABCD;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        chk("t6_pending", ready_o, 1'b0);
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_rst_seg", seg_o, 7'h7F);
        chk("t6_rst_an", an_o, 4'hF);
        chk("t6_rst_ready", ready_o, 1'b1);
        @(negedge clk);
        rst_i = 1'b0;
        wait_frame("t6_frame");
        @(posedge clk);
        #1;
        read_frame(4);
        chk_frame("t6", 7'h40, 7'h40, 7'h40, 7'h40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
